// File: rtl/crypto_job_sequencer_pkg.sv
// rtl/crypto_job_sequencer_pkg.sv - stage indices, FSM encodings and result-entry layout for the X25519 job sequencer
package crypto_job_sequencer_pkg;

   localparam int STG_KEY  = 0;
   localparam int STG_MONT = 1;
   localparam int STG_INV  = 2;
   localparam int STG_MUL  = 3;
   localparam int STG_MOD  = 4;
   localparam int NUM_CRYPTO_STAGES = STG_MOD + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_PUSH   = 2'd3;

   // Result entry is {error, tag, data} with data in the low bits.
   localparam int FLD_DATA_LSB = 0;

   function automatic int fld_tag_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int fld_err_bit(input int data_w, input int tag_w);
      return data_w + tag_w;
   endfunction

endpackage

// File: rtl/crypto_res_fifo.sv
// rtl/crypto_res_fifo.sv - first-word-fall-through result FIFO with registered storage and level output
module crypto_res_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     crypto_clk,
   input  logic                     crypto_reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] level_q;

   always_ff @(posedge crypto_clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // Depth is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge crypto_clk) begin
      if (crypto_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   assign rd_valid = (level_q != '0);
   assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign level    = level_q;

   assert property (@(posedge crypto_clk) disable iff (crypto_reset)
      !(wr_en && (level_q == LVL_W'(DEPTH))));
   assert property (@(posedge crypto_clk) disable iff (crypto_reset)
      !(rd_en && (level_q == '0)));

endmodule

// File: rtl/crypto_job_sequencer.sv
// rtl/crypto_job_sequencer.sv - sequences the X25519 stages per job with skip masks and a watchdog, queues tagged results
module crypto_job_sequencer
   import crypto_job_sequencer_pkg::*;
#(
   parameter int NUM_STAGES  = NUM_CRYPTO_STAGES,
   parameter int DATA_W      = 255,
   parameter int TAG_W       = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 1048575
) (
   input  logic                          crypto_clk,
   input  logic                          crypto_reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [NUM_STAGES-1:0]         req_skip,
   input  logic [TAG_W-1:0]              req_tag,
   output logic [NUM_STAGES-1:0]         stage_start,
   input  logic [NUM_STAGES-1:0]         stage_done,
   input  logic [DATA_W-1:0]             final_data,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [DATA_W-1:0]             res_data,
   output logic [TAG_W-1:0]              res_tag,
   output logic                          res_error,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam int CNT_W   = $clog2(TIMEOUT_CYC + 1);
   localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int TAG_LSB = fld_tag_lsb(DATA_W);
   localparam int ERR_BIT = fld_err_bit(DATA_W, TAG_W);
   localparam int ENT_W   = ERR_BIT + 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [1:0]            state_q;
   logic [IDX_W-1:0]      idx_q;
   logic [NUM_STAGES-1:0] skip_q;
   logic [TAG_W-1:0]      tag_q;
   logic                  err_q;
   logic [DATA_W-1:0]     data_q;
   logic [CNT_W-1:0]      cnt_q;

   logic                  accept;
   logic                  first_found;
   logic [IDX_W-1:0]      first_idx;
   logic                  next_found;
   logic [IDX_W-1:0]      next_idx;
   logic                  fifo_wr;
   logic                  fifo_rd;
   logic [ENT_W-1:0]      wr_entry;
   logic [ENT_W-1:0]      rd_entry;

   // Lowest unskipped stage of a new request, and lowest unskipped stage above the current one.
   always_comb begin
      first_found = 1'b0;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (!req_skip[i]) begin
            first_found = 1'b1;
            first_idx   = IDX_W'(i);
         end
         if (!skip_q[i] && (IDX_W'(i) > idx_q)) begin
            next_found = 1'b1;
            next_idx   = IDX_W'(i);
         end
      end
   end

   assign req_ready = !crypto_reset && (state_q == ST_IDLE) && (fifo_level < LVL_W'(FIFO_DEPTH));
   assign accept    = req_valid && req_ready;
   assign busy      = (state_q != ST_IDLE);

   always_ff @(posedge crypto_clk) begin
      if (crypto_reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         skip_q  <= '0;
         tag_q   <= '0;
         err_q   <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  skip_q <= req_skip;
                  tag_q  <= req_tag;
                  data_q <= '0;
                  idx_q  <= first_idx;
                  if (first_found) begin
                     err_q   <= 1'b0;
                     state_q <= ST_LAUNCH;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= ST_PUSH;
                  end
               end
            end
            ST_LAUNCH: begin
               cnt_q   <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done in the same cycle the watchdog expires still counts as success.
               if (stage_done[idx_q]) begin
                  if (next_found) begin
                     idx_q   <= next_idx;
                     state_q <= ST_LAUNCH;
                  end else begin
                     data_q  <= final_data;
                     err_q   <= 1'b0;
                     state_q <= ST_PUSH;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  data_q  <= '0;
                  err_q   <= 1'b1;
                  state_q <= ST_PUSH;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_PUSH: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      stage_start = '0;
      if (state_q == ST_LAUNCH) begin
         stage_start[idx_q] = 1'b1;
      end
   end

   assign fifo_wr = (state_q == ST_PUSH);
   assign fifo_rd = res_valid && res_ready;

   assign wr_entry[FLD_DATA_LSB +: DATA_W] = data_q;
   assign wr_entry[TAG_LSB +: TAG_W]       = tag_q;
   assign wr_entry[ERR_BIT]                = err_q;

   crypto_res_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_res_fifo (
      .crypto_clk   (crypto_clk),
      .crypto_reset (crypto_reset),
      .wr_en        (fifo_wr),
      .wr_data      (wr_entry),
      .rd_en        (fifo_rd),
      .rd_valid     (res_valid),
      .rd_data      (rd_entry),
      .level        (fifo_level)
   );

   assign res_data  = rd_entry[FLD_DATA_LSB +: DATA_W];
   assign res_tag   = rd_entry[TAG_LSB +: TAG_W];
   assign res_error = rd_entry[ERR_BIT];

endmodule

// File: tb/tb_crypto_job_sequencer.sv
// tb/tb_crypto_job_sequencer.sv - directed self-checking bench for crypto_job_sequencer
module tb_crypto_job_sequencer;
   import crypto_job_sequencer_pkg::*;

   localparam int NS = 5;
   localparam int DW = 255;
   localparam int TW = 4;
   localparam int FD = 4;
   localparam int TO = 16;
   localparam int DONE_LAT = 10;

   logic          crypto_clk = 1'b0;
   logic          crypto_reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [NS-1:0] req_skip = '0;
   logic [TW-1:0] req_tag = '0;
   logic [NS-1:0] stage_start;
   logic [NS-1:0] stage_done = '0;
   logic [DW-1:0] final_data = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [DW-1:0] res_data;
   logic [TW-1:0] res_tag;
   logic          res_error;
   logic          busy;
   logic [2:0]    fifo_level;

   crypto_job_sequencer #(
      .NUM_STAGES  (NS),
      .DATA_W      (DW),
      .TAG_W       (TW),
      .FIFO_DEPTH  (FD),
      .TIMEOUT_CYC (TO)
   ) dut (
      .crypto_clk   (crypto_clk),
      .crypto_reset (crypto_reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_skip     (req_skip),
      .req_tag      (req_tag),
      .stage_start  (stage_start),
      .stage_done   (stage_done),
      .final_data   (final_data),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_tag      (res_tag),
      .res_error    (res_error),
      .busy         (busy),
      .fifo_level   (fifo_level)
   );

   always #5 crypto_clk = ~crypto_clk;

   int cyc = 0;
   always @(posedge crypto_clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Stage model: each started stage answers DONE_LAT cycles later unless hung.
   logic [NS-1:0] hang_mask = '0;
   logic [NS-1:0] force_done = '0;
   logic [DW-1:0] fdata = '0;
   bit            pend = 0;
   int            pend_cnt = 0;
   int            pend_idx = 0;
   int            onehot_bad = 0;
   int            start_idx_q[$];
   int            start_cyc_q[$];

   initial forever begin
      @(negedge crypto_clk);
      stage_done = force_done;
      force_done = '0;
      final_data = {DW{1'b1}};
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            stage_done[pend_idx] = 1'b1;
            final_data = fdata;
            pend = 0;
         end
      end
      if (stage_start != '0) begin
         if ($countones(stage_start) != 1) onehot_bad++;
         for (int i = 0; i < NS; i++) begin
            if (stage_start[i]) begin
               start_idx_q.push_back(i);
               start_cyc_q.push_back(cyc);
               if (!hang_mask[i]) begin
                  pend = 1;
                  pend_cnt = DONE_LAT;
                  pend_idx = i;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge crypto_clk);
      #1;
   endtask

   task automatic clear_log();
      start_idx_q.delete();
      start_cyc_q.delete();
   endtask

   task automatic submit(input logic [NS-1:0] skip, input logic [TW-1:0] tag, output int t);
      int n;
      n = 0;
      while (!req_ready && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) chk("submit_ready_timeout", req_ready, 1);
      req_valid = 1'b1;
      req_skip  = skip;
      req_tag   = tag;
      t = cyc;
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_valid(input int maxc, output int win);
      win = -1;
      for (int i = 0; i < maxc; i++) begin
         if (res_valid) begin
            win = cyc;
            break;
         end
         step();
      end
      if (win < 0) chk("wait_valid_timeout", res_valid, 1);
   endtask

   task automatic pop();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   int t;
   int w;
   int s;
   int n4;

   initial begin
      // Reset state
      repeat (3) step();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stage_start", stage_start, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_fifo_level", fifo_level, 0);
      chk("rst_res_data", res_data, 0);
      crypto_reset = 1'b0;
      step();
      chk("idle_req_ready", req_ready, 1);

      // All stages, tag 3
      clear_log();
      fdata = DW'(16'h1234);
      submit(5'b00000, 4'd3, t);
      chk("t1_first_start", stage_start, 5'b00001);
      chk("t1_busy", busy, 1);
      wait_valid(200, w);
      chk("t1_valid_cycle", w, t + 57);
      chk("t1_num_starts", start_idx_q.size(), 5);
      for (int k = 0; k < 5 && k < start_idx_q.size(); k++) begin
         chk($sformatf("t1_start%0d_idx", k), start_idx_q[k], k);
         chk($sformatf("t1_start%0d_cyc", k), start_cyc_q[k], t + 1 + 11 * k);
      end
      chk("t1_data", res_data, 256'h1234);
      chk("t1_tag", res_tag, 3);
      chk("t1_err", res_error, 0);
      pop();
      chk("t1_level_after_pop", fifo_level, 0);

      // Skip keygen
      clear_log();
      fdata = DW'(16'hABCD);
      submit(5'b00001, 4'd5, t);
      chk("t2_first_start", stage_start, 5'b00010);
      wait_valid(200, w);
      chk("t2_valid_cycle", w, t + 46);
      chk("t2_num_starts", start_idx_q.size(), 4);
      for (int k = 0; k < 4 && k < start_idx_q.size(); k++)
         chk($sformatf("t2_start%0d_idx", k), start_idx_q[k], k + 1);
      chk("t2_data", res_data, 256'hABCD);
      chk("t2_tag", res_tag, 5);
      chk("t2_err", res_error, 0);
      pop();

      // All stages skipped
      clear_log();
      submit(5'b11111, 4'd7, t);
      chk("t3_no_start", stage_start, 0);
      wait_valid(10, w);
      chk("t3_valid_cycle", w, t + 2);
      chk("t3_err", res_error, 1);
      chk("t3_data", res_data, 0);
      chk("t3_tag", res_tag, 7);
      chk("t3_num_starts", start_idx_q.size(), 0);
      pop();

      // Watchdog on stage 2
      clear_log();
      hang_mask = 5'b00100;
      fdata = DW'(8'h55);
      submit(5'b00000, 4'd9, t);
      wait_valid(300, w);
      chk("t4_num_starts", start_idx_q.size(), 3);
      s = (start_cyc_q.size() >= 3) ? start_cyc_q[2] : 0;
      chk("t4_timeout_cycle", w, s + TO + 2);
      chk("t4_err", res_error, 1);
      chk("t4_data", res_data, 0);
      chk("t4_tag", res_tag, 9);
      pop();
      hang_mask = '0;
      force_done = 5'b00100;
      repeat (3) step();
      chk("t4_late_done_level", fifo_level, 0);
      chk("t4_late_done_busy", busy, 0);
      clear_log();
      fdata = DW'(8'h77);
      submit(5'b11000, 4'd10, t);
      wait_valid(200, w);
      chk("t4_next_valid_cycle", w, t + 35);
      chk("t4_next_data", res_data, 256'h77);
      chk("t4_next_err", res_error, 0);
      chk("t4_next_tag", res_tag, 10);
      pop();

      // FIFO fill with consumer stalled
      for (int k = 1; k <= 4; k++) submit(5'b11111, TW'(k), t);
      repeat (3) step();
      chk("t5_full_level", fifo_level, 4);
      chk("t5_full_req_ready", req_ready, 0);
      req_valid = 1'b1;
      req_skip  = 5'b11111;
      req_tag   = 4'd5;
      repeat (3) step();
      chk("t5_blocked_busy", busy, 0);
      chk("t5_blocked_level", fifo_level, 4);
      chk("t5_pop1_tag", res_tag, 1);
      pop();
      chk("t5_reopen", req_ready, 1);
      step();
      req_valid = 1'b0;
      chk("t5_accept_busy", busy, 1);
      chk("t5_pop2_tag", res_tag, 2);
      pop();
      chk("t5_level_push_pop", fifo_level, 3);
      for (int k = 3; k <= 5; k++) begin
         chk($sformatf("t5_pop%0d_tag", k), res_tag, k);
         chk($sformatf("t5_pop%0d_err", k), res_error, 1);
         pop();
      end
      chk("t5_drained", fifo_level, 0);

      // Reset while waiting on stage 3
      submit(5'b11111, 4'd1, t);
      wait_valid(10, w);
      clear_log();
      fdata = DW'(8'h99);
      submit(5'b00000, 4'd2, t);
      for (int i = 0; i < 100; i++) begin
         if (start_idx_q.size() > 0 && start_idx_q[start_idx_q.size() - 1] == 3) break;
         step();
      end
      chk("t6_reached_stage3", start_idx_q.size(), 4);
      chk("t6_level_before", fifo_level, 1);
      repeat (3) step();
      crypto_reset = 1'b1;
      step();
      chk("t6_stage_start", stage_start, 0);
      chk("t6_busy", busy, 0);
      chk("t6_res_valid", res_valid, 0);
      chk("t6_res_data", res_data, 0);
      chk("t6_res_tag", res_tag, 0);
      chk("t6_res_error", res_error, 0);
      chk("t6_level", fifo_level, 0);
      chk("t6_req_ready", req_ready, 0);
      step();
      crypto_reset = 1'b0;
      repeat (30) step();
      n4 = 0;
      foreach (start_idx_q[i]) if (start_idx_q[i] == STG_MOD) n4++;
      chk("t6_no_stage4", n4, 0);
      chk("t6_level_after", fifo_level, 0);
      chk("t6_busy_after", busy, 0);

      chk("onehot_starts", onehot_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=%0d exp=finish", cyc);
      $fatal(1);
   end

endmodule
